// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle RISC-V controller: FSM states, opcodes,
// ALU codes and datapath mux selects.
package mc_pkg;

  localparam int OPCODE_W   = 7;
  localparam int ALU_CTRL_W = 3;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXEC_R,
    S_EXEC_I, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_LUI, S_HALT
  } state_t;

  // Which ALU operation a state wants; FUNCT defers to funct3/funct7_5
  typedef enum logic [1:0] {ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT, ALUOP_PASSB} alu_op_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_PASSB = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_4     = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  function automatic logic [2:0] imm_sel(input logic [6:0] op);
    case (op)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      OP_LUI:    return IMM_U;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control: maps the state's requested ALU class plus the
// instruction's funct fields onto the 3-bit ALU operation code.
module alu_decoder
  import mc_pkg::*;
#(
    parameter int OPCODE_W   = mc_pkg::OPCODE_W,
    parameter int ALU_CTRL_W = mc_pkg::ALU_CTRL_W
) (
    input  alu_op_t               alu_op,
    input  logic [OPCODE_W-1:0]   opcode,
    input  logic [2:0]            funct3,
    input  logic                  funct7_5,
    output logic [ALU_CTRL_W-1:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_SUB:   alu_control = ALU_SUB;
            ALUOP_PASSB: alu_control = ALU_PASSB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // I-type reuses bit 30 as immediate, so only R-type may subtract
                    3'b000:  alu_control = (opcode == OP_RTYPE && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default:     alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RISC-V control FSM. Define ILLEGAL_TRAP_EN to trap unknown opcodes
// and unsupported funct3 into a sticky HALT state with an illegal flag port.
module multicycle_controller
  import mc_pkg::*;
#(
    parameter int ALU_CTRL_W = mc_pkg::ALU_CTRL_W,
    parameter int OPCODE_W   = mc_pkg::OPCODE_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [OPCODE_W-1:0]   opcode,
    input  logic [2:0]            funct3,
    input  logic                  funct7_5,
    input  logic                  zero,
    output logic                  pc_write,
    output logic                  adr_src,
    output logic                  mem_write,
    output logic                  ir_write,
    output logic                  reg_write,
    output logic [1:0]            result_src,
    output logic [1:0]            alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [2:0]            imm_src,
`ifdef ILLEGAL_TRAP_EN
    output logic                  illegal,
`endif
    output logic [ALU_CTRL_W-1:0] alu_control
);

    state_t                state, state_next;
    alu_op_t               alu_op;
    logic [ALU_CTRL_W-1:0] alu_ctrl_dec;
    logic                  pc_write_c, adr_src_c, mem_write_c, ir_write_c, reg_write_c;
    logic [1:0]            result_src_c, alu_src_a_c, alu_src_b_c;

`ifdef ILLEGAL_TRAP_EN
    logic exec_ok, branch_ok;
    assign exec_ok   = funct3 inside {3'b000, 3'b010, 3'b110, 3'b111};
    assign branch_ok = funct3 inside {3'b000, 3'b001};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_RTYPE:          state_next = S_EXEC_R;
                    OP_ITYPE:          state_next = S_EXEC_I;
                    OP_BRANCH:         state_next = S_BRANCH;
                    OP_JAL:            state_next = S_JAL;
                    OP_JALR:           state_next = S_JALR;
                    OP_LUI:            state_next = S_LUI;
`ifdef ILLEGAL_TRAP_EN
                    default:           state_next = S_HALT;
`else
                    default:           state_next = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   state_next = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_next = S_MEMWB;
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: state_next = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
            S_EXEC_R, S_EXEC_I: state_next = exec_ok ? S_ALUWB : S_HALT;
            S_BRANCH:           state_next = branch_ok ? S_FETCH : S_HALT;
`else
            S_EXEC_R, S_EXEC_I: state_next = S_ALUWB;
            S_BRANCH:           state_next = S_FETCH;
`endif
            S_ALUWB:    state_next = S_FETCH;
            S_JALR:     state_next = S_JAL;
            S_JAL:      state_next = S_ALUWB;
            S_LUI:      state_next = S_ALUWB;
            S_HALT:     state_next = S_HALT;
            default:    state_next = S_FETCH;
        endcase
    end

    always_comb begin
        pc_write_c   = 1'b0;
        adr_src_c    = 1'b0;
        mem_write_c  = 1'b0;
        ir_write_c   = 1'b0;
        reg_write_c  = 1'b0;
        result_src_c = RES_ALUOUT;
        alu_src_a_c  = SRCA_PC;
        alu_src_b_c  = SRCB_RS2;
        alu_op       = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                ir_write_c   = 1'b1;
                pc_write_c   = 1'b1;
                alu_src_b_c  = SRCB_4;
                result_src_c = RES_ALURES;
            end
            S_DECODE: begin
                alu_src_a_c = SRCA_OLDPC;
                alu_src_b_c = SRCB_IMM;
            end
            S_MEMADR, S_JALR: begin
                alu_src_a_c = SRCA_RS1;
                alu_src_b_c = SRCB_IMM;
            end
            S_MEMREAD:  adr_src_c = 1'b1;
            S_MEMWB: begin
                result_src_c = RES_RDATA;
                reg_write_c  = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src_c   = 1'b1;
                mem_write_c = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a_c = SRCA_RS1;
                alu_op      = ALUOP_FUNCT;
            end
            S_EXEC_I: begin
                alu_src_a_c = SRCA_RS1;
                alu_src_b_c = SRCB_IMM;
                alu_op      = ALUOP_FUNCT;
            end
            S_ALUWB:    reg_write_c = 1'b1;
            S_BRANCH: begin
                alu_src_a_c = SRCA_RS1;
                alu_op      = ALUOP_SUB;
                case (funct3)
                    3'b000:  pc_write_c = zero;
                    3'b001:  pc_write_c = ~zero;
                    default: pc_write_c = 1'b0;
                endcase
            end
            S_JAL: begin
                alu_src_a_c = SRCA_OLDPC;
                alu_src_b_c = SRCB_4;
                pc_write_c  = 1'b1;
            end
            S_LUI: begin
                alu_src_b_c = SRCB_IMM;
                alu_op      = ALUOP_PASSB;
            end
            default: ;
        endcase
    end

    alu_decoder #(.OPCODE_W(OPCODE_W), .ALU_CTRL_W(ALU_CTRL_W)) u_alu_decoder (
        .alu_op      (alu_op),
        .opcode      (opcode),
        .funct3      (funct3),
        .funct7_5    (funct7_5),
        .alu_control (alu_ctrl_dec)
    );

    // Reset parks the FSM in FETCH, so gate everything to keep FETCH's enables quiet
    assign pc_write    = rst_n & pc_write_c;
    assign adr_src     = rst_n & adr_src_c;
    assign mem_write   = rst_n & mem_write_c;
    assign ir_write    = rst_n & ir_write_c;
    assign reg_write   = rst_n & reg_write_c;
    assign result_src  = rst_n ? result_src_c : 2'b00;
    assign alu_src_a   = rst_n ? alu_src_a_c  : 2'b00;
    assign alu_src_b   = rst_n ? alu_src_b_c  : 2'b00;
    assign imm_src     = rst_n ? imm_sel(opcode) : 3'b000;
    assign alu_control = rst_n ? alu_ctrl_dec : '0;
`ifdef ILLEGAL_TRAP_EN
    assign illegal     = rst_n & (state == S_HALT);
`endif

endmodule
